// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter (8-bit word, optional even/odd parity) among
//   N_REQ requesters. A round-robin grant selects one pending requester. Its
//   word and parity settings are latched, the transmitter start is driven, the
//   transmitter busy flag is followed, and a done pulse goes back to the winner.
//
// Ports
//   CLK, RST      rising-edge clock, asynchronous active-high reset
//   req           per-requester pending flag (level, held until done[i])
//   req_data      word of requester i at [8*i+7:8*i]
//   req_par_en    per-requester parity enable
//   req_par_odd   per-requester parity type (1 = odd, 0 = even)
//   slowo_trans   latched word to the transmitter
//   start_trans   start request to the transmitter
//   czy_parz      latched parity enable to the transmitter
//   jaki_parz     latched parity type to the transmitter
//   transmisja    transmitter busy flag (high while a frame is on the line)
//   done          one-cycle pulse, one-hot, when the granted frame finishes
//   err           one-cycle pulse when the transmitter never acknowledged start
//   busy          arbiter is not idle
//   grant_idx     index of the current or last granted requester
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int IDX_W       = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_par_en,
  input  logic [N_REQ-1:0]     req_par_odd,
  output logic [7:0]           slowo_trans,
  output logic                 start_trans,
  output logic                 czy_parz,
  output logic                 jaki_parz,
  input  logic                 transmisja,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_idx
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [1:0] ST_BUSY     = 2'd3;

  // The timeout fires on the cycle whose increment would reach ACK_TIMEOUT.
  localparam logic [3:0]       CNT_LAST  = 4'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]   N_REQ_EXT = (IDX_W + 1)'(N_REQ);

  logic [1:0]       state_q,     state_d;
  logic [IDX_W-1:0] rr_q,        rr_d;
  logic [3:0]       cnt_q,       cnt_d;
  logic [7:0]       slowo_q,     slowo_d;
  logic             par_en_q,    par_en_d;
  logic             par_odd_q,   par_odd_d;
  logic             start_q,     start_d;
  logic [N_REQ-1:0] done_q,      done_d;
  logic             err_q,       err_d;
  logic [IDX_W-1:0] grant_q,     grant_d;

  logic [N_REQ-1:0] eligible;
  logic             found;
  logic [IDX_W-1:0] winner;
  logic [IDX_W:0]   scan_sum;
  logic [IDX_W-1:0] scan_idx;
  logic [7:0]       win_data;
  logic [IDX_W-1:0] next_rr;

  // Round-robin pick. A requester whose done pulse is out this cycle still
  // shows req high (it only drops after seeing done), so it is masked here to
  // avoid granting the same word a second time.
  always_comb begin
    eligible = req & ~done_q;
    found    = 1'b0;
    winner   = rr_q;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_q} + (IDX_W + 1)'(k);
      if (scan_sum >= N_REQ_EXT) begin
        scan_sum = scan_sum - N_REQ_EXT;
      end
      scan_idx = scan_sum[IDX_W-1:0];
      if (!found && eligible[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // Word of the winner, selected with constant slices.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        win_data = req_data[i*8 +: 8];
      end
    end
  end

  // Pointer moves past the last grant, whether it finished or timed out.
  assign next_rr = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;

  // Main sequencer. Latched word and parity are only written in IDLE, so they
  // stay stable from ISSUE through BUSY regardless of req_* activity.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    slowo_d   = slowo_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    start_d   = start_q;
    done_d    = '0;
    err_d     = 1'b0;
    grant_d   = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (!transmisja && found) begin
          slowo_d   = win_data;
          par_en_d  = req_par_en[winner];
          par_odd_d = req_par_odd[winner];
          grant_d   = winner;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (transmisja) begin
          start_d = 1'b0;
          state_d = ST_BUSY;
        end else if (cnt_q == CNT_LAST) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          rr_d    = next_rr;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_BUSY: begin
        if (!transmisja) begin
          done_d[grant_q] = 1'b1;
          rr_d            = next_rr;
          state_d         = ST_IDLE;
        end
      end
      default: begin
        start_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // All outputs are registered so reset clears them immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      cnt_q     <= '0;
      slowo_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= '0;
      err_q     <= 1'b0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      slowo_q   <= slowo_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      start_q   <= start_d;
      done_q    <= done_d;
      err_q     <= err_d;
      grant_q   <= grant_d;
    end
  end

  assign slowo_trans = slowo_q;
  assign start_trans = start_q;
  assign czy_parz    = par_en_q;
  assign jaki_parz   = par_odd_q;
  assign done        = done_q;
  assign err         = err_q;
  assign grant_idx   = grant_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (N_REQ = 4). The transmitter is played
//   by hand through the transmisja input; expected values are written out
//   step by step.
module tb_uart_tx_arbiter;

  logic        CLK;
  logic        RST;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_par_en;
  logic [3:0]  req_par_odd;
  logic [7:0]  slowo_trans;
  logic        start_trans;
  logic        czy_parz;
  logic        jaki_parz;
  logic        transmisja;
  logic [3:0]  done;
  logic        err;
  logic        busy;
  logic [1:0]  grant_idx;

  int n_asserts = 0;
  int n_fail    = 0;
  int high_cnt;
  int idle_cnt;

  uart_tx_arbiter #(.N_REQ(4), .IDX_W(2), .ACK_TIMEOUT(15)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req         (req),
    .req_data    (req_data),
    .req_par_en  (req_par_en),
    .req_par_odd (req_par_odd),
    .slowo_trans (slowo_trans),
    .start_trans (start_trans),
    .czy_parz    (czy_parz),
    .jaki_parz   (jaki_parz),
    .transmisja  (transmisja),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .grant_idx   (grant_idx)
  );

  // 10 ns clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock edge and settle 1 ns after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d,
                               input logic [3:0] pen, input logic [3:0] podd,
                               input logic tx);
    req         = r;
    req_data    = d;
    req_par_en  = pen;
    req_par_odd = podd;
    transmisja  = tx;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Serve one granted frame: wait for start, acknowledge, hold the line busy,
  // release, expect the one-hot done, then set req for the following cycle.
  task automatic serveFrame(input int exp_idx, input logic [7:0] exp_data,
                            input logic [3:0] req_after);
    int waited;
    logic [3:0] exp_done;
    waited   = 0;
    exp_done = 4'b0001 << exp_idx;
    while (start_trans !== 1'b1 && waited < 6) begin
      tick();
      waited++;
    end
    checkOutput("start_seen", 32'(start_trans), 32'd1);
    checkOutput("grant_idx", 32'(grant_idx), 32'(exp_idx));
    checkOutput("slowo_trans", 32'(slowo_trans), 32'(exp_data));
    transmisja = 1'b1;
    tick();
    checkOutput("start_drop", 32'(start_trans), 32'd0);
    repeat (3) tick();
    checkOutput("busy_frame", 32'(busy), 32'd1);
    transmisja = 1'b0;
    tick();
    checkOutput("done_pulse", 32'(done), 32'(exp_done));
    req = req_after;
    tick();
    checkOutput("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    applyStimulus(4'b0000, 32'h0, 4'b0000, 4'b0000, 1'b0);

    // Reset state
    tick();
    checkOutput("rst_start", 32'(start_trans), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_grant", 32'(grant_idx), 32'd0);
    checkOutput("rst_slowo", 32'(slowo_trans), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    RST = 1'b0;
    tick();

    // Round robin with all four requesters held
    applyStimulus(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b0000, 4'b0000, 1'b0);
    tick();
    serveFrame(0, 8'h11, 4'b1111);
    serveFrame(1, 8'h22, 4'b1111);
    serveFrame(2, 8'h33, 4'b1111);
    serveFrame(3, 8'h44, 4'b1111);
    serveFrame(0, 8'h11, 4'b0000);

    // Single requester with odd parity, two-cycle start latency
    applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'h99}, 4'b0001, 4'b0001, 1'b0);
    tick();
    checkOutput("single_latch_start", 32'(start_trans), 32'd0);
    checkOutput("single_busy", 32'(busy), 32'd1);
    checkOutput("single_slowo", 32'(slowo_trans), 32'h99);
    checkOutput("single_czy", 32'(czy_parz), 32'd1);
    checkOutput("single_jaki", 32'(jaki_parz), 32'd1);
    checkOutput("single_grant", 32'(grant_idx), 32'd0);
    tick();
    checkOutput("single_start", 32'(start_trans), 32'd1);
    tick();
    checkOutput("single_start_hold", 32'(start_trans), 32'd1);
    transmisja = 1'b1;
    tick();
    checkOutput("single_start_drop", 32'(start_trans), 32'd0);
    checkOutput("single_busy_tx", 32'(busy), 32'd1);
    repeat (2) tick();
    checkOutput("single_no_done", 32'(done), 32'd0);
    transmisja = 1'b0;
    tick();
    checkOutput("single_done", 32'(done), 32'b0001);
    checkOutput("single_idle", 32'(busy), 32'd0);
    req = 4'b0000;
    tick();
    checkOutput("single_done_clear", 32'(done), 32'd0);
    checkOutput("single_no_regrant", 32'(busy), 32'd0);

    // Timeout on requester 2 while 3 is also pending (pointer at 1)
    applyStimulus(4'b1100, {8'h3C, 8'hC3, 8'h00, 8'h00}, 4'b0100, 4'b1000, 1'b0);
    tick();
    checkOutput("to_grant", 32'(grant_idx), 32'd2);
    checkOutput("to_slowo", 32'(slowo_trans), 32'hC3);
    checkOutput("to_czy", 32'(czy_parz), 32'd1);
    checkOutput("to_jaki", 32'(jaki_parz), 32'd0);
    tick();
    checkOutput("to_start", 32'(start_trans), 32'd1);
    high_cnt = 0;
    repeat (14) begin
      tick();
      if (start_trans === 1'b1 && err === 1'b0) high_cnt++;
    end
    checkOutput("to_wait_cycles", 32'(high_cnt), 32'd14);
    tick();
    checkOutput("to_start_drop", 32'(start_trans), 32'd0);
    checkOutput("to_err", 32'(err), 32'd1);
    checkOutput("to_no_done", 32'(done), 32'd0);
    checkOutput("to_idle", 32'(busy), 32'd0);
    tick();
    checkOutput("to_err_clear", 32'(err), 32'd0);
    checkOutput("to_next_grant", 32'(grant_idx), 32'd3);
    checkOutput("to_next_busy", 32'(busy), 32'd1);
    checkOutput("to_next_slowo", 32'(slowo_trans), 32'h3C);
    checkOutput("to_next_czy", 32'(czy_parz), 32'd0);
    checkOutput("to_next_jaki", 32'(jaki_parz), 32'd1);
    serveFrame(3, 8'h3C, 4'b0100);
    serveFrame(2, 8'hC3, 4'b0000);

    // Stability of the latched word during BUSY (pointer at 3)
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'h55, 8'h00}, 4'b0000, 4'b0000, 1'b0);
    tick();
    checkOutput("stab_grant", 32'(grant_idx), 32'd1);
    tick();
    checkOutput("stab_start", 32'(start_trans), 32'd1);
    transmisja = 1'b1;
    tick();
    req_data    = {8'h00, 8'h00, 8'hAA, 8'h00};
    req_par_en  = 4'b0010;
    req_par_odd = 4'b0010;
    tick();
    checkOutput("stab_slowo", 32'(slowo_trans), 32'h55);
    checkOutput("stab_czy", 32'(czy_parz), 32'd0);
    checkOutput("stab_jaki", 32'(jaki_parz), 32'd0);
    tick();
    checkOutput("stab_slowo_late", 32'(slowo_trans), 32'h55);
    transmisja = 1'b0;
    tick();
    checkOutput("stab_done", 32'(done), 32'b0010);
    req = 4'b0000;
    tick();

    // Foreign frame on the line blocks the grant
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'hAA, 8'h00}, 4'b0000, 4'b0000, 1'b1);
    idle_cnt = 0;
    repeat (3) begin
      tick();
      if (start_trans === 1'b0 && busy === 1'b0) idle_cnt++;
    end
    checkOutput("foreign_blocked", 32'(idle_cnt), 32'd3);
    transmisja = 1'b0;
    tick();
    checkOutput("foreign_grant_busy", 32'(busy), 32'd1);
    checkOutput("foreign_grant", 32'(grant_idx), 32'd1);
    checkOutput("foreign_slowo", 32'(slowo_trans), 32'hAA);
    tick();
    checkOutput("foreign_start", 32'(start_trans), 32'd1);
    transmisja = 1'b1;
    tick();
    checkOutput("foreign_in_busy", 32'(busy), 32'd1);

    // Asynchronous reset in the middle of BUSY
    #2;
    RST = 1'b1;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_grant", 32'(grant_idx), 32'd0);
    checkOutput("arst_slowo", 32'(slowo_trans), 32'd0);
    checkOutput("arst_start", 32'(start_trans), 32'd0);
    checkOutput("arst_czy", 32'(czy_parz), 32'd0);
    checkOutput("arst_jaki", 32'(jaki_parz), 32'd0);
    checkOutput("arst_done", 32'(done), 32'd0);
    checkOutput("arst_err", 32'(err), 32'd0);
    tick();
    RST        = 1'b0;
    transmisja = 1'b0;
    req        = 4'b1010;
    tick();
    checkOutput("arst_rr_cleared", 32'(grant_idx), 32'd1);
    checkOutput("arst_regrant_busy", 32'(busy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
